// File: rtl/core_mem_stage.sv
// rtl/core_mem_stage.sv - MEM-stage load/store unit driving a req/gnt/rvalid data-memory port
module core_mem_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            valid_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    output logic            stall_o,
    output logic            done_o,
    output logic            misalign_o,
    output logic            err_o,
    output logic [XLEN-1:0] dmem_rd_data_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [31:0] TMO = TIMEOUT;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    logic        mem_op;
    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic        expired;
    logic [31:0] shifted;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Stores only recognise SB/SH explicitly; every other store code is a full word.
    always_comb begin
        mem_op     = valid_i & (mem_read_i | mem_write_i);
        is_byte    = (funct3_i == 3'b000) | (mem_read_i & (funct3_i == 3'b100));
        is_half    = (funct3_i == 3'b001) | (mem_read_i & (funct3_i == 3'b101));
        misaligned = is_half ? addr_i[0] : (!is_byte && (addr_i[1:0] != 2'b00));
        expired    = (TMO != 32'd0) && ((cnt_q + 32'd1) >= TMO);
    end

    always_comb begin
        shifted  = dmem_rdata_i >> {addr_q[1:0], 3'b000};
        half_sel = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        funct3_d  = funct3_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        stall_o      = 1'b0;
        done_o       = 1'b0;
        misalign_o   = 1'b0;
        err_o        = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = 4'b0000;
        dmem_wdata_o = '0;

        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o  = 1'b1;
                        state_d  = S_REQ;
                        addr_d   = addr_i;
                        funct3_d = funct3_i;
                        we_d     = mem_write_i;
                        err_d    = 1'b0;
                        cnt_d    = 32'd0;
                        if (is_byte) begin
                            be_d    = 4'b0001 << addr_i[1:0];
                            wdata_d = {4{wr_data_i[7:0]}};
                        end else if (is_half) begin
                            be_d    = 4'b0011 << addr_i[1:0];
                            wdata_d = {2{wr_data_i[15:0]}};
                        end else begin
                            be_d    = 4'b1111;
                            wdata_d = wr_data_i;
                        end
                    end
                end
            end
            S_REQ: begin
                stall_o      = 1'b1;
                dmem_req_o   = 1'b1;
                dmem_we_o    = we_q;
                dmem_addr_o  = {addr_q[31:2], 2'b00};
                dmem_be_o    = be_q;
                dmem_wdata_o = wdata_q;
                cnt_d        = cnt_q + 32'd1;
                // A grant on the final allowed cycle still counts as accepted.
                if (dmem_gnt_i) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end else if (expired) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rd_data_d = 32'd0;
                    end
                end
            end
            S_WAIT: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 32'd1;
                if (dmem_rvalid_i) begin
                    rd_data_d = load_ext;
                    state_d   = S_DONE;
                end else if (expired) begin
                    rd_data_d = 32'd0;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb dmem_rd_data_o = rd_data_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            funct3_q  <= 3'b000;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'd0;
            rd_data_q <= 32'd0;
            err_q     <= 1'b0;
            cnt_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            funct3_q  <= funct3_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_core_mem_stage.sv
// tb/tb_core_mem_stage.sv - directed and randomized checks of core_mem_stage against a reference model
module tb_core_mem_stage;

    localparam int T = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        valid_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wr_data_i;
    logic        stall_o;
    logic        done_o;
    logic        misalign_o;
    logic        err_o;
    logic [31:0] dmem_rd_data_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    core_mem_stage #(.XLEN(32), .TIMEOUT(T)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .valid_i        (valid_i),
        .mem_read_i     (mem_read_i),
        .mem_write_i    (mem_write_i),
        .funct3_i       (funct3_i),
        .addr_i         (addr_i),
        .wr_data_i      (wr_data_i),
        .stall_o        (stall_o),
        .done_o         (done_o),
        .misalign_o     (misalign_o),
        .err_o          (err_o),
        .dmem_rd_data_o (dmem_rd_data_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_be_o      (dmem_be_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rd = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs;
        valid_i       = 1'b0;
        mem_read_i    = 1'b0;
        mem_write_i   = 1'b0;
        funct3_i      = 3'($urandom);
        addr_i        = $urandom;
        wr_data_i     = $urandom;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = $urandom;
    endtask

    function automatic int size_of(input bit ld, input logic [2:0] f3);
        if (f3 == 3'b000 || (ld && f3 == 3'b100)) return 1;
        if (f3 == 3'b001 || (ld && f3 == 3'b101)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
        int              sz;
        longint unsigned mask;
        longint unsigned v;
        sz   = size_of(1'b1, f3);
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = (64'(rd) >> (8 * off)) & mask;
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (~mask & 64'hFFFF_FFFF);
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_be(input int sz, input logic [1:0] off);
        return 4'(((32'd1 << sz) - 32'd1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] wd);
        if (sz == 1) return wd[7:0] * 32'h0101_0101;
        if (sz == 2) return wd[15:0] * 32'h0001_0001;
        return wd;
    endfunction

    task automatic do_op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rvd);
        int sz;
        int req_cycles;
        int wait_cycles;
        int kab;
        bit to;
        sz = size_of(ld, f3);
        wait_cycles = 0;
        if (gd >= T) begin
            req_cycles = T;
            to = 1'b1;
        end else begin
            req_cycles = gd + 1;
            to = 1'b0;
            if (ld) begin
                kab = (T - gd - 2 > 0) ? T - gd - 2 : 0;
                if (rvd <= kab) wait_cycles = rvd + 1;
                else begin
                    wait_cycles = kab + 1;
                    to = 1'b1;
                end
            end
        end
        chk("idle_no_req", dmem_req_o, 0);
        valid_i = 1'b1; mem_read_i = ld; mem_write_i = !ld;
        funct3_i = f3; addr_i = a; wr_data_i = wd;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        #1;
        chk("accept_stall", stall_o, 1);
        chk("accept_misalign", misalign_o, 0);
        chk("accept_req", dmem_req_o, 0);
        step;
        for (int i = 0; i < req_cycles; i++) begin
            idle_inputs();
            dmem_gnt_i    = (i == gd);
            dmem_rvalid_i = 1'($urandom);
            #1;
            chk("req_req", dmem_req_o, 1);
            chk("req_stall", stall_o, 1);
            chk("req_we", dmem_we_o, !ld);
            chk("req_addr", dmem_addr_o, a & 32'hFFFF_FFFC);
            chk("req_be", dmem_be_o, model_be(sz, a[1:0]));
            if (!ld) chk("req_wdata", dmem_wdata_o, model_wdata(sz, wd));
            chk("req_done", done_o, 0);
            step;
        end
        for (int j = 0; j < wait_cycles; j++) begin
            idle_inputs();
            dmem_rvalid_i = (j == rvd);
            if (j == rvd) dmem_rdata_i = rd;
            #1;
            chk("wait_req", dmem_req_o, 0);
            chk("wait_stall", stall_o, 1);
            chk("wait_done", done_o, 0);
            step;
        end
        idle_inputs();
        dmem_rvalid_i = 1'($urandom);
        valid_i = 1'b1; mem_write_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0400;
        #1;
        chk("done_pulse", done_o, 1);
        chk("done_err", err_o, to);
        chk("done_stall", stall_o, 0);
        chk("done_req", dmem_req_o, 0);
        if (ld) exp_rd = to ? 32'd0 : load_model(f3, a[1:0], rd);
        step;
        idle_inputs();
        #1;
        chk("rd_data", dmem_rd_data_o, exp_rd);
        chk("done_clear", done_o, 0);
    endtask

    task automatic do_misalign(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        chk("idle_no_req", dmem_req_o, 0);
        valid_i = 1'b1; mem_read_i = ld; mem_write_i = !ld;
        funct3_i = f3; addr_i = a; wr_data_i = $urandom;
        #1;
        chk("mis_pulse", misalign_o, 1);
        chk("mis_stall", stall_o, 0);
        chk("mis_req", dmem_req_o, 0);
        step;
        idle_inputs();
        #1;
        chk("mis_after_req", dmem_req_o, 0);
        chk("mis_after_pulse", misalign_o, 0);
        chk("mis_rd_data", dmem_rd_data_o, exp_rd);
    endtask

    initial begin
        bit          ld;
        logic [2:0]  f3;
        logic [31:0] a;
        int          sz;

        rstn_i = 1'b0;
        idle_inputs();
        step;
        step;
        chk("rst_stall", stall_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_misalign", misalign_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rd_data", dmem_rd_data_o, 0);
        chk("rst_req", dmem_req_o, 0);
        chk("rst_we", dmem_we_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_be", dmem_be_o, 0);
        chk("rst_wdata", dmem_wdata_o, 0);
        rstn_i = 1'b1;
        step;

        do_op(1'b1, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 0);
        chk("lw_100", dmem_rd_data_o, 32'hDEAD_BEEF);
        do_op(1'b1, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_FF7F, 0, 0);
        chk("lb_103", dmem_rd_data_o, 32'hFFFF_FF80);
        do_op(1'b1, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_FF7F, 0, 0);
        chk("lbu_103", dmem_rd_data_o, 32'h0000_0080);
        do_op(1'b1, 3'b001, 32'h0000_0102, 32'd0, 32'h80FF_FF7F, 0, 0);
        chk("lh_102", dmem_rd_data_o, 32'hFFFF_80FF);
        do_op(1'b0, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'd0, 0, 0);
        do_op(1'b0, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'd0, 0, 0);
        chk("store_keeps_rd", dmem_rd_data_o, 32'hFFFF_80FF);
        do_misalign(1'b1, 3'b010, 32'h0000_0102);
        do_op(1'b0, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'd0, 3, 0);
        do_op(1'b1, 3'b010, 32'h0000_0304, 32'd0, 32'h1111_2222, 20, 0);
        chk("timeout_rd_zero", dmem_rd_data_o, 32'd0);
        do_op(1'b1, 3'b101, 32'h0000_0302, 32'd0, 32'hBEEF_0000, 1, 0);

        chk("nonmem_idle", dmem_req_o, 0);
        valid_i = 1'b1;
        #1;
        chk("nonmem_stall", stall_o, 0);
        chk("nonmem_mis", misalign_o, 0);
        step;
        idle_inputs();
        #1;
        chk("nonmem_req", dmem_req_o, 0);

        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0500;
        #1;
        step;
        idle_inputs();
        dmem_gnt_i = 1'b1;
        #1;
        step;
        idle_inputs();
        rstn_i = 1'b0;
        #1;
        chk("rst_wait_stall", stall_o, 1);
        step;
        chk("rst_mid_req", dmem_req_o, 0);
        chk("rst_mid_stall", stall_o, 0);
        chk("rst_mid_rd", dmem_rd_data_o, 0);
        chk("rst_mid_done", done_o, 0);
        exp_rd = 32'd0;
        rstn_i = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_gnt_i = 1'b1;
        dmem_rdata_i = 32'hFFFF_FFFF;
        step;
        idle_inputs();
        #1;
        chk("late_rvalid_rd", dmem_rd_data_o, 0);
        chk("late_rvalid_done", done_o, 0);
        chk("late_rvalid_req", dmem_req_o, 0);

        for (int n = 0; n < 150; n++) begin
            ld = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            sz = size_of(ld, f3);
            if ((a[1:0] % sz) != 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    a = a & ~32'(sz - 1);
                end else begin
                    do_misalign(ld, f3, a);
                    continue;
                end
            end
            do_op(ld, f3, a, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
